// File: rtl/soc_reset_seq_pkg.sv
// Shared types and constants for the SoC reset sequencer.
package soc_reset_seq_pkg;

    localparam int unsigned LOST_CNT_W = 8;

    // Sequencer states; encoding is kept stable for debug visibility.
    typedef enum logic [2:0] {
        StWaitLock  = 3'd0,
        StStable    = 3'd1,
        StRelPeriph = 3'd2,
        StRelCpu    = 3'd3,
        StRun       = 3'd4
    } seq_state_e;

    // True in every state where the peripheral reset has been released.
    function automatic logic periph_released(seq_state_e s);
        return (s == StRelPeriph) || (s == StRelCpu) || (s == StRun);
    endfunction

    // True in every state where the CPU reset has been released.
    function automatic logic cpu_released(seq_state_e s);
        return (s == StRelCpu) || (s == StRun);
    endfunction

endpackage

// File: rtl/soc_reset_seq_reset_sync.sv
// Multi-flop synchroniser with asynchronous clear and synchronous propagation.
// Used both for reset release (d tied high) and for asynchronous level inputs.
module soc_reset_seq_reset_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift chain: cleared immediately by resetn, fills from d one stage per edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/soc_reset_seq.sv
// Reset sequencer: waits for stable PLL lock, then releases peripheral reset,
// then CPU reset, then signals ready. Lock loss or a hold request aborts back
// to the start; lock losses after release are counted for debug.
module soc_reset_seq
    import soc_reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned STAGE_GAP   = 16,
    parameter int unsigned CNT_W       = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pll_lock,
    input  logic                  ext_hold,
    output logic                  periph_rst_n,
    output logic                  cpu_rst_n,
    output logic                  ready,
    output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

    localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLast  = CNT_W'(STAGE_GAP - 1);

    logic rst_sync_n;
    logic lock_s;
    logic hold_s;
    logic abort;

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOST_CNT_W-1:0] lost_q, lost_d;
    logic                  periph_q, periph_d;
    logic                  cpu_q, cpu_d;
    logic                  ready_q, ready_d;

    soc_reset_seq_reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (1'b1),
        .q      (rst_sync_n)
    );

    soc_reset_seq_reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_lock),
        .q      (lock_s)
    );

    soc_reset_seq_reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_hold_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (ext_hold),
        .q      (hold_s)
    );

    // Next-state, shared counter, lost-lock counter and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = lost_q;
        abort   = (state_q != StWaitLock) && (!lock_s || hold_s);

        if (abort) begin
            // Abort wins over any same-cycle transition.
            state_d = StWaitLock;
            cnt_d   = '0;
            // Only lock loss after the peripherals were released counts.
            if (!lock_s && periph_released(state_q) && (lost_q != '1)) begin
                lost_d = lost_q + LOST_CNT_W'(1);
            end
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    cnt_d = '0;
                    if (lock_s && !hold_s) begin
                        state_d = StStable;
                    end
                end
                StStable: begin
                    if (cnt_q == LockLast) begin
                        state_d = StRelPeriph;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StRelPeriph: begin
                    if (cnt_q == GapLast) begin
                        state_d = StRelCpu;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StRelCpu: begin
                    if (cnt_q == GapLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StRun: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they change on the same edge.
        periph_d = periph_released(state_d);
        cpu_d    = cpu_released(state_d);
        ready_d  = (state_d == StRun);
    end

    // State, counters and output flops; cleared asynchronously by the synced reset.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q  <= StWaitLock;
            cnt_q    <= '0;
            lost_q   <= '0;
            periph_q <= 1'b0;
            cpu_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lost_q   <= lost_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
            ready_q  <= ready_d;
        end
    end

    assign periph_rst_n  = periph_q;
    assign cpu_rst_n     = cpu_q;
    assign ready         = ready_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_soc_reset_seq.sv
// Directed bench for soc_reset_seq with SYNC_STAGES=2, LOCK_CYCLES=8, STAGE_GAP=4.
// Edge numbers count posedges after the reference point of each test.
module tb_soc_reset_seq;

    logic       clk;
    logic       resetn;
    logic       pll_lock;
    logic       ext_hold;
    logic       periph_rst_n;
    logic       cpu_rst_n;
    logic       ready;
    logic [7:0] lock_lost_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    soc_reset_seq #(
        .SYNC_STAGES (2),
        .LOCK_CYCLES (8),
        .STAGE_GAP   (4),
        .CNT_W       (12)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pll_lock      (pll_lock),
        .ext_hold      (ext_hold),
        .periph_rst_n  (periph_rst_n),
        .cpu_rst_n     (cpu_rst_n),
        .ready         (ready),
        .lock_lost_cnt (lock_lost_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic check_all_low(input string tag);
        check_val({tag, "_periph"}, 32'(periph_rst_n), 32'd0);
        check_val({tag, "_cpu"}, 32'(cpu_rst_n), 32'd0);
        check_val({tag, "_ready"}, 32'(ready), 32'd0);
    endtask

    // Release ordering must hold on every cycle of every test.
    always @(negedge clk) begin
        check_val("order_cpu_periph", 32'(cpu_rst_n & ~periph_rst_n), 32'd0);
        check_val("order_ready_cpu", 32'(ready & ~cpu_rst_n), 32'd0);
    end

    initial begin
        resetn   = 1'b0;
        pll_lock = 1'b1;
        ext_hold = 1'b0;

        // T1 power-up
        repeat (5) tick();
        check_all_low("t1_rst");
        check_val("t1_rst_cnt", 32'(lock_lost_cnt), 32'd0);
        resetn = 1'b1;
        edge_n = 0;
        run_to(10);
        check_val("t1_periph_e10", 32'(periph_rst_n), 32'd0);
        run_to(11);
        check_val("t1_periph_e11", 32'(periph_rst_n), 32'd1);
        check_val("t1_cpu_e11", 32'(cpu_rst_n), 32'd0);
        run_to(14);
        check_val("t1_cpu_e14", 32'(cpu_rst_n), 32'd0);
        run_to(15);
        check_val("t1_cpu_e15", 32'(cpu_rst_n), 32'd1);
        check_val("t1_ready_e15", 32'(ready), 32'd0);
        run_to(18);
        check_val("t1_ready_e18", 32'(ready), 32'd0);
        run_to(19);
        check_val("t1_ready_e19", 32'(ready), 32'd1);
        check_val("t1_cnt", 32'(lock_lost_cnt), 32'd0);

        // T2 one-cycle lock flicker while counting in STABLE
        resetn = 1'b0;
        tick();
        tick();
        check_all_low("t2_rst");
        resetn = 1'b1;
        edge_n = 0;
        run_to(8);
        pll_lock = 1'b0;
        run_to(9);
        pll_lock = 1'b1;
        run_to(11);
        check_val("t2_periph_e11", 32'(periph_rst_n), 32'd0);
        run_to(19);
        check_val("t2_periph_e19", 32'(periph_rst_n), 32'd0);
        run_to(20);
        check_val("t2_periph_e20", 32'(periph_rst_n), 32'd1);
        run_to(24);
        check_val("t2_cpu_e24", 32'(cpu_rst_n), 32'd1);
        run_to(27);
        check_val("t2_ready_e27", 32'(ready), 32'd0);
        run_to(28);
        check_val("t2_ready_e28", 32'(ready), 32'd1);
        check_val("t2_cnt", 32'(lock_lost_cnt), 32'd0);

        // T3 lock loss in RUN for 3 cycles, then full re-run
        pll_lock = 1'b0;
        edge_n   = 0;
        run_to(2);
        check_val("t3_ready_e2", 32'(ready), 32'd1);
        run_to(3);
        check_all_low("t3_abort");
        check_val("t3_cnt", 32'(lock_lost_cnt), 32'd1);
        pll_lock = 1'b1;
        run_to(13);
        check_val("t3_periph_e13", 32'(periph_rst_n), 32'd0);
        run_to(14);
        check_val("t3_periph_e14", 32'(periph_rst_n), 32'd1);
        run_to(18);
        check_val("t3_cpu_e18", 32'(cpu_rst_n), 32'd1);

        // T4 two-cycle hold pulse while in REL_CPU
        ext_hold = 1'b1;
        run_to(20);
        ext_hold = 1'b0;
        check_val("t4_cpu_e20", 32'(cpu_rst_n), 32'd1);
        check_val("t4_periph_e20", 32'(periph_rst_n), 32'd1);
        run_to(21);
        check_all_low("t4_abort");
        check_val("t4_cnt_abort", 32'(lock_lost_cnt), 32'd1);
        run_to(30);
        check_val("t4_periph_e30", 32'(periph_rst_n), 32'd0);
        run_to(31);
        check_val("t4_periph_e31", 32'(periph_rst_n), 32'd1);
        run_to(35);
        check_val("t4_cpu_e35", 32'(cpu_rst_n), 32'd1);
        run_to(39);
        check_val("t4_ready_e39", 32'(ready), 32'd1);
        check_val("t4_cnt", 32'(lock_lost_cnt), 32'd1);

        // T5 300 further lock losses from RUN; counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            repeat (3) tick();
            pll_lock = 1'b1;
            repeat (19) tick();
            if (i == 9) check_val("t5_cnt_11", 32'(lock_lost_cnt), 32'd11);
            if (i == 253) check_val("t5_cnt_255", 32'(lock_lost_cnt), 32'd255);
        end
        check_val("t5_ready", 32'(ready), 32'd1);
        check_val("t5_cnt_sat", 32'(lock_lost_cnt), 32'd255);
        resetn = 1'b0;
        #1;
        check_val("t5_cnt_clr", 32'(lock_lost_cnt), 32'd0);
        check_all_low("t5_rst");
        tick();

        // T6 asynchronous reset in the middle of REL_PERIPH
        resetn = 1'b1;
        edge_n = 0;
        run_to(12);
        check_val("t6_periph_e12", 32'(periph_rst_n), 32'd1);
        check_val("t6_cpu_e12", 32'(cpu_rst_n), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check_all_low("t6_async");
        check_val("t6_cnt", 32'(lock_lost_cnt), 32'd0);
        tick();
        tick();
        check_all_low("t6_held");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
